// File: rtl/imm_pkg.sv
// Shared immediate-decode types: format codes, base opcodes and the XLEN legality check.
package imm_pkg;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_Z    = 3'd6
  } fmt_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  function automatic bit xlen_legal(input int xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

endpackage

// File: rtl/imm_extract.sv
// Combinational instruction -> {immediate, format} decoder, sign/zero-extended to XLEN.
// Build macro IMM_ILLEGAL_DET_EN adds the 'illegal' output.
module imm_extract
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output fmt_e            fmt
`ifdef IMM_ILLEGAL_DET_EN
  ,output logic           illegal
`endif
);

  logic [6:0] opcode;
  logic       known_opcode;

  assign opcode = instr[6:0];

  always_comb begin
    imm          = '0;
    fmt          = FMT_NONE;
    known_opcode = 1'b1;
    case (opcode)
      OP_LOAD, OP_IMM, OP_JALR: begin
        fmt = FMT_I;
        imm = XLEN'($signed(instr[31:20]));
      end
      OP_STORE: begin
        fmt = FMT_S;
        imm = XLEN'($signed({instr[31:25], instr[11:7]}));
      end
      OP_BRANCH: begin
        fmt = FMT_B;
        imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
      end
      OP_LUI, OP_AUIPC: begin
        fmt = FMT_U;
        imm = XLEN'($signed({instr[31:12], 12'b0}));
      end
      OP_JAL: begin
        fmt = FMT_J;
        imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
      end
      OP_SYSTEM: begin
        // Only the immediate CSR forms carry an operand (zimm in the rs1 field)
        if (instr[14]) begin
          fmt = FMT_Z;
          imm = XLEN'(instr[19:15]);
        end
      end
      default: known_opcode = 1'b0;
    endcase
  end

  logic unused_funct3_low;
  assign unused_funct3_low = ^instr[13:12];

`ifdef IMM_ILLEGAL_DET_EN
  assign illegal = !known_opcode || (instr[1:0] != 2'b11);
`else
  logic unused_known_opcode;
  assign unused_known_opcode = known_opcode;
`endif

endmodule

// File: rtl/imm_decode_stage.sv
// Registered immediate-decode stage: decode + PC-relative target ahead of a main/skid buffer pair.
// Build macro IMM_ILLEGAL_DET_EN adds out_illegal, carried with each entry.
module imm_decode_stage
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic [XLEN-1:0]  out_target,
  output logic [XLEN-1:0]  out_pc,
  output logic [TAG_W-1:0] out_tag
`ifdef IMM_ILLEGAL_DET_EN
  ,output logic            out_illegal
`endif
);

  if (!xlen_legal(XLEN)) begin : g_xlen_check
    $error("imm_decode_stage: XLEN must be 32 or 64");
  end

  logic [XLEN-1:0] ext_imm;
  fmt_e            ext_fmt;
  logic [XLEN-1:0] new_target;

  // Entry layout (LSB first): imm, fmt, target, pc, tag[, illegal]
`ifdef IMM_ILLEGAL_DET_EN
  localparam int PW = 3*XLEN + 3 + TAG_W + 1;
  logic ext_illegal;
`else
  localparam int PW = 3*XLEN + 3 + TAG_W;
`endif

  logic [PW-1:0] in_entry;

  imm_extract #(.XLEN(XLEN)) u_extract (
    .instr   (in_instr),
    .imm     (ext_imm),
    .fmt     (ext_fmt)
`ifdef IMM_ILLEGAL_DET_EN
    ,.illegal(ext_illegal)
`endif
  );

  assign new_target = in_pc + ext_imm;

`ifdef IMM_ILLEGAL_DET_EN
  assign in_entry = {ext_illegal, in_tag, in_pc, new_target, ext_fmt, ext_imm};
`else
  assign in_entry = {in_tag, in_pc, new_target, ext_fmt, ext_imm};
`endif

  logic [PW-1:0] main_q, main_d;
  logic [PW-1:0] skid_q, skid_d;
  logic          main_valid_q, main_valid_d;
  logic          skid_valid_q, skid_valid_d;
  logic          in_ready_q, in_ready_d;
  logic          accept, drain;

  assign accept = in_valid && in_ready_q;
  assign drain  = main_valid_q && out_ready;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || drain) begin
      // Main slot frees up this edge: the older skid entry always wins it
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_d       = in_entry;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = in_entry;
      skid_valid_d = 1'b1;
    end
    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = main_valid_q;
  assign out_imm    = main_q[0 +: XLEN];
  assign out_fmt    = main_q[XLEN +: 3];
  assign out_target = main_q[XLEN+3 +: XLEN];
  assign out_pc     = main_q[2*XLEN+3 +: XLEN];
  assign out_tag    = main_q[3*XLEN+3 +: TAG_W];
`ifdef IMM_ILLEGAL_DET_EN
  assign out_illegal = main_q[PW-1];
`endif

endmodule
